// File: rtl/lif_pkg.sv
// Shared constants and types for the time-multiplexed LIF layer.
package lif_pkg;

  localparam int N_STAGES = 5;
  localparam int INPUTS   = 2 ** N_STAGES;
  localparam int IN_BYTES = INPUTS / 8;
  localparam int NEURONS  = 8;
  localparam int OUT_BITS = N_STAGES + 2;

  localparam int CFG_ADDR_W = $clog2(NEURONS * IN_BYTES + 2);
  localparam int IDX_W      = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int CNT_W      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  // Configuration registers sit directly above the weight bytes.
  localparam logic [CFG_ADDR_W-1:0] ADDR_SHIFT = CFG_ADDR_W'(NEURONS * IN_BYTES);
  localparam logic [CFG_ADDR_W-1:0] ADDR_TETA  = CFG_ADDR_W'(NEURONS * IN_BYTES + 1);

  localparam int MINUS_TETA_RST = -5;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

endpackage

// File: rtl/lif_layer_scheduler_state_mem.sv
// Per-neuron storage: weights, membrane potentials and spike history,
// read through a single neuron-index mux feeding the shared core.
module lif_state_mem
  import lif_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_w_we,
  input  logic [IDX_W-1:0]    i_w_neuron,
  input  logic [CNT_W-1:0]    i_w_byte,
  input  logic [7:0]          i_w_data,
  input  logic                i_upd_en,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [OUT_BITS-1:0] i_u_new,
  input  logic                i_spike_new,
  input  logic                i_clr,
  output logic [INPUTS-1:0]   o_w,
  output logic [OUT_BITS-1:0] o_u,
  output logic                o_was_spike
);

  logic [INPUTS-1:0]   r_w   [NEURONS];
  logic [OUT_BITS-1:0] r_u   [NEURONS];
  logic                r_was [NEURONS];

  // Weight bytes written from the configuration port.
  // NOTE: these arrays are small flops, not SRAM, and the layer must start
  // from a known zero state, so every entry is reset explicitly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NEURONS; n++) r_w[n] <= '0;
    end else if (i_w_we) begin
      r_w[i_w_neuron][8*i_w_byte +: 8] <= i_w_data;
    end
  end

  // Potential and spike history: cleared on request, else updated per neuron.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NEURONS; n++) begin
        r_u[n]   <= '0;
        r_was[n] <= 1'b0;
      end
    end else if (i_clr) begin
      for (int n = 0; n < NEURONS; n++) begin
        r_u[n]   <= '0;
        r_was[n] <= 1'b0;
      end
    end else if (i_upd_en) begin
      r_u[i_idx]   <= i_u_new;
      r_was[i_idx] <= i_spike_new;
    end
  end

  assign o_w         = r_w[i_idx];
  assign o_u         = r_u[i_idx];
  assign o_was_spike = r_was[i_idx];

endmodule

// File: rtl/lif_layer_scheduler.sv
// Layer scheduler: collects one timestep of input bytes, sweeps the shared
// LIF core over every virtual neuron, then offers the spike vector.
module lif_layer_scheduler
  import lif_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic                  cfg_busy,
  input  logic                  clr_state,
  input  logic                  x_valid,
  input  logic [7:0]            x_data,
  output logic                  x_ready,
  output logic [NEURONS-1:0]    spikes,
  output logic                  spikes_valid,
  input  logic                  spikes_ready,
  output logic [INPUTS-1:0]     core_w,
  output logic [INPUTS-1:0]     core_x,
  output logic [2:0]            core_shift,
  output logic [OUT_BITS-1:0]   core_prev_u,
  output logic [OUT_BITS-1:0]   core_minus_teta,
  output logic                  core_was_spike,
  input  logic [OUT_BITS-1:0]   core_u_out,
  input  logic                  core_spike
);

  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(IN_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NEURONS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [INPUTS-1:0]     r_x;
  logic [2:0]            r_shift;
  logic [OUT_BITS-1:0]   r_minus_teta;
  logic [NEURONS-1:0]    r_spikes;

  logic                  w_x_ready;
  logic                  w_busy;
  logic                  w_valid;
  logic                  w_x_acc;
  logic                  w_cfg_ok;
  logic                  w_w_we;
  logic                  w_clr;
  logic                  w_upd_en;
  logic [IDX_W-1:0]      w_w_neuron;
  logic [CNT_W-1:0]      w_w_byte;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_x_ready   = 1'b0;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      LOAD: begin
        w_x_ready = 1'b1;
        if (x_valid && (r_byte_cnt == LAST_BYTE)) w_state_nxt = COMPUTE;
      end
      COMPUTE: begin
        w_busy = 1'b1;
        if (r_idx == LAST_NEURON) w_state_nxt = OUTPUT;
      end
      OUTPUT: begin
        w_valid = 1'b1;
        if (spikes_ready) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign w_x_acc    = x_valid & w_x_ready;
  assign w_cfg_ok   = cfg_we & ~w_busy;
  assign w_w_we     = w_cfg_ok & (cfg_addr < ADDR_SHIFT);
  assign w_w_neuron = IDX_W'(cfg_addr / CFG_ADDR_W'(IN_BYTES));
  assign w_w_byte   = CNT_W'(cfg_addr % CFG_ADDR_W'(IN_BYTES));
  assign w_clr      = clr_state & (r_state == LOAD);
  assign w_upd_en   = (r_state == COMPUTE);

  // Input shifter, byte counter, neuron index and spike output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_idx      <= '0;
      r_x        <= '0;
      r_spikes   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_x_acc) begin
            // First byte of a timestep ends up in the MSBs.
            r_x <= (r_x << 8) | INPUTS'(x_data);
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt <= '0;
              r_idx      <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          r_spikes[r_idx] <= core_spike;
          r_idx           <= (r_idx == LAST_NEURON) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Layer-wide leak shift and threshold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_minus_teta <= OUT_BITS'(MINUS_TETA_RST);
    end else if (w_cfg_ok) begin
      if (cfg_addr == ADDR_SHIFT) r_shift      <= cfg_data[2:0];
      if (cfg_addr == ADDR_TETA)  r_minus_teta <= cfg_data[OUT_BITS-1:0];
    end
  end

  lif_state_mem u_mem (
    .clk         (clk),
    .reset       (reset),
    .i_w_we      (w_w_we),
    .i_w_neuron  (w_w_neuron),
    .i_w_byte    (w_w_byte),
    .i_w_data    (cfg_data),
    .i_upd_en    (w_upd_en),
    .i_idx       (r_idx),
    .i_u_new     (core_u_out),
    .i_spike_new (core_spike),
    .i_clr       (w_clr),
    .o_w         (core_w),
    .o_u         (core_prev_u),
    .o_was_spike (core_was_spike)
  );

  assign x_ready         = w_x_ready;
  assign cfg_busy        = w_busy;
  assign spikes_valid    = w_valid;
  assign spikes          = r_spikes;
  assign core_x          = r_x;
  assign core_shift      = r_shift;
  assign core_minus_teta = r_minus_teta;

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
Time-multiplexes one combinational LIF neuron core across NEURONS virtual neurons to form a small spiking layer. Holds per-neuron weights, membrane potentials and spike history, plus the layer-wide leak shift and threshold. Each timestep it accepts INPUTS bits as a byte stream, then sequences the core once per neuron, one neuron per cycle. It returns the layer spike vector through a valid/ready handshake. It sits between the tt_um_* top-level I/O glue and the neuron core instance.

Parameters:
N_STAGES, 5, adder-tree depth of the neuron core.
INPUTS, 2**N_STAGES, synapses per neuron; must be a multiple of 8.
IN_BYTES, INPUTS/8, input and weight bytes per neuron.
NEURONS, 8, virtual neurons served by the single core.
OUT_BITS, N_STAGES+2, membrane-potential precision.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  configuration byte write strobe
cfg_addr  in  clog2(NEURONS*IN_BYTES+2)  configuration address
cfg_data  in  8  configuration data
cfg_busy  out  1  high while in COMPUTE; writes are ignored while high
clr_state  in  1  pulse: clear all potentials and spike history
x_valid  in  1  input byte valid
x_data  in  8  input byte
x_ready  out  1  input byte accepted when x_valid & x_ready
spikes  out  NEURONS  layer spike vector
spikes_valid  out  1  spikes holds a completed timestep
spikes_ready  in  1  consumer accepts spikes
core_w  out  INPUTS  weights of the current neuron
core_x  out  INPUTS  input vector
core_shift  out  3  leak shift
core_prev_u  out  OUT_BITS  stored potential of the current neuron
core_minus_teta  out  OUT_BITS  negated threshold
core_was_spike  out  1  previous spike of the current neuron
core_u_out  in  OUT_BITS  new potential from the core
core_spike  in  1  spike from the core

Behaviour:
- Reset values: state LOAD, byte_cnt 0, idx 0, x 0, all weights 0, all u 0, all was_spike 0, shift 0, minus_teta -5 (OUT_BITS two's complement, 7'h7B by default).
- Output reset values: spikes 0, spikes_valid 0, x_ready 1, cfg_busy 0.
- Reset is asynchronous. Asserting it mid-operation aborts any timestep with no partial output.

Configuration address map:
- Address a < NEURONS*IN_BYTES writes weight byte b = a%IN_BYTES of neuron a/IN_BYTES, bits [8b+7:8b].
- Address NEURONS*IN_BYTES writes shift <= cfg_data[2:0].
- Address NEURONS*IN_BYTES+1 writes minus_teta <= cfg_data[OUT_BITS-1:0].
- Other addresses are ignored.
- Writes are accepted in LOAD and OUTPUT and ignored in COMPUTE.

FSM:
- LOAD:
  - x_ready=1.
  - Each accepted byte does x <= {x[INPUTS-9:0], x_data}, so the first byte ends up in the MSBs, and byte_cnt increments.
  - On the IN_BYTES-th accept: byte_cnt <= 0, idx <= 0, go to COMPUTE.
- COMPUTE:
  - x_ready=0, cfg_busy=1.
  - Core outputs are driven from idx: core_w=w[idx], core_prev_u=u[idx], core_was_spike=was_spike[idx]. core_x, core_shift and core_minus_teta are constant.
  - Each edge: u[idx] <= core_u_out, was_spike[idx] <= core_spike, spikes[idx] <= core_spike, idx++.
  - After idx = NEURONS-1, go to OUTPUT.
- OUTPUT:
  - spikes_valid=1; spikes is held stable.
  - On spikes_ready: spikes_valid <= 0, go to LOAD.
- Latency: the last input byte accepted at edge t gives COMPUTE during cycles t+1..t+NEURONS and spikes_valid high from cycle t+NEURONS+1.
- Throughput: one timestep per IN_BYTES+NEURONS+1 cycles when the consumer is always ready.
- clr_state is honoured in LOAD only; it zeroes u[] and was_spike[] and leaves weights, shift and minus_teta unchanged. If clr_state coincides with a byte accept, both take effect.
- x_valid in COMPUTE or OUTPUT is not accepted; the producer holds the byte.
- Potential arithmetic belongs entirely to the core. The scheduler stores core_u_out unmodified, wrapping at OUT_BITS.

Decomposition:
- Shared package lif_pkg: N_STAGES default, OUT_BITS derivation, the config address constants (ADDR_SHIFT, ADDR_TETA), the state enum {LOAD, COMPUTE, OUTPUT}, and the reset threshold constant MINUS_TETA_RST = -5.
- One natural sub-module, lif_state_mem: the weight, u and was_spike register arrays with the write/clear ports and an idx read mux. The FSM, input shifter and output register stay in the top module.

Test Plan:
1. Reset: assert reset asynchronously mid-COMPUTE -> immediately x_ready=1, spikes_valid=0, cfg_busy=0, core_shift=0, core_minus_teta=7'h7B.
2. Config map: write addr 5 = 8'hA5, addr 32 = 3'd2, addr 33 = 7'h7C -> during COMPUTE at idx=1, core_w[15:8]=8'hA5 and the rest of core_w = 0; core_shift=2; core_minus_teta=7'h7C.
3. Timing: bytes 8'h11,22,33,44 accepted at edges t..t+3 -> core_x=32'h11223344; x_ready=0 and cfg_busy=1 for cycles t+4..t+11; idx sweeps 0..7; spikes_valid=1 from cycle t+12.
4. Backpressure: hold spikes_ready=0 for 5 cycles -> spikes stable and x_ready=0 throughout; pulse spikes_ready -> spikes_valid=0 and x_ready=1 the next cycle.
5. Ignored write: cfg_we to addr 0 during COMPUTE -> w[0] unchanged in the next timestep.
6. Clear and history, with a model core whose core_spike=1 for idx 3 only:
   - After timestep 1: spikes=8'b0000_1000.
   - In timestep 2, core_was_spike=1 at idx 3 only.
   - Pulse clr_state in LOAD -> in timestep 3, core_prev_u=0 and core_was_spike=0 for every idx.
